// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared state encoding, default parameters and timer sizing for the pulse stretcher
//
// Contents:
//   state_t                : IDLE / HIGH / GAP state encoding
//   DEFAULT_HIGH_CYCLES    : default number of cycles level stays high per event
//   DEFAULT_GAP_CYCLES     : default minimum low cycles between events
//   DEFAULT_PEND_W         : default width of the pending-event counter
//   timer_width()          : width of the shared duration counter
package pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEFAULT_HIGH_CYCLES = 4;
    localparam int DEFAULT_GAP_CYCLES  = 2;
    localparam int DEFAULT_PEND_W      = 3;

    // The counter only ever holds (duration - 1), so clog2 of the longer
    // duration is enough; keep at least one bit so the port is never empty.
    function automatic int timer_width(input int high_cycles, input int gap_cycles);
        int longest;
        longest = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/pulse_stretcher_timer.sv
// rtl/pulse_stretcher_timer.sv - loadable down-counter that times the HIGH and GAP phases
//
// Ports:
//   clk        : clock, all updates on rising edge
//   rst_n      : asynchronous active-low reset, clears the count
//   load       : load strobe, count takes load_value on the next edge
//   load_value : value loaded (phase length minus one)
//   done       : high while the count is zero (last cycle of the current phase)
module cycle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches each sampled request cycle into a fixed-width output window
//
// Ports:
//   clk      : clock, all updates on rising edge
//   rst_n    : asynchronous active-low reset
//   pulse    : event request, every cycle sampled high is one event
//   level    : stretched output, high for HIGH_CYCLES cycles per event
//   busy     : high whenever the FSM is not idle
//   pending  : accepted events waiting for their window to start
//   overflow : one-cycle strobe, an event was dropped because pending was full
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int HIGH_CYCLES = DEFAULT_HIGH_CYCLES,
    parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
    parameter int PEND_W      = DEFAULT_PEND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse,
    output logic              level,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int TW = timer_width(HIGH_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0]     HIGH_LOAD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    generate
        if (HIGH_CYCLES < 1) begin : g_bad_high
            $error("pulse_stretcher: HIGH_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("pulse_stretcher: GAP_CYCLES must be >= 1");
        end
    endgenerate

    state_t         state;
    logic           timer_done;
    logic           timer_load;
    logic [TW-1:0]  timer_value;
    logic           have_pending;
    logic           high_end;
    logic           gap_end;
    logic           restart;
    logic           enq;
    logic           deq;

    assign have_pending = (pending != '0);
    assign high_end     = (state == ST_HIGH) && timer_done;
    assign gap_end      = (state == ST_GAP) && timer_done;
    // Last gap cycle goes straight back to HIGH if anything is queued or
    // a new request arrives in that very cycle.
    assign restart      = gap_end && (have_pending || pulse);

    assign timer_load   = ((state == ST_IDLE) && pulse) || high_end || restart;
    assign timer_value  = high_end ? GAP_LOAD : HIGH_LOAD;

    // A request on the last gap cycle with nothing queued starts the next
    // window itself rather than passing through the queue.
    assign enq = pulse && (state != ST_IDLE) && !(gap_end && !have_pending);
    assign deq = gap_end && have_pending;

    cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            level    <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pulse) begin
                        state <= ST_HIGH;
                        level <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (timer_done) begin
                        state <= ST_GAP;
                        level <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (timer_done) begin
                        if (restart) begin
                            state <= ST_HIGH;
                            level <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase

            // Enqueue and dequeue in the same cycle cancel, so a full queue
            // only drops an event when nothing leaves it.
            case ({enq, deq})
                2'b10: begin
                    if (pending == PEND_MAX) begin
                        overflow <= 1'b1;
                    end else begin
                        pending <= pending + 1'b1;
                    end
                end
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

endmodule
